fibo_gen_top: RTL and testbench

FIBO_GEN_TOP -- requirements
Module: fibo_gen_top

---
 rtl/fibo_gen_top.sv | 171 +++++++++++++++++
 tb/tb_fibo_gen_top.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fibo_gen_top.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fibo_gen_top -- 4-bit Fibonacci term generator
//
// Purpose:
//   Emits one Fibonacci term per rising clock edge from a registered output.
//   The default build restarts the series at 0,1 once the term 13 has been
//   shown, which gives the period-8 series 0,1,1,2,3,5,8,13. When the
//   FIBO_GEN_MOD_WRAP_EN macro is defined, the restart-detect stage is
//   compiled out and the series becomes a plain mod-16 Fibonacci series
//   with period 24.
//
// Hierarchy:
//   fibo_state_reg       - cur/nxt registers with asynchronous reset to 0/1
//   fibo_adder4          - 4-bit cur+nxt adder, carry discarded
//   fibo_restart_detect  - flags cur == 13 (default build only)
//
// Ports (fibo_gen_top):
//   clk          in   1  single clock; all state updates on its rising edge
//   reset        in   1  asynchronous active-low reset (cur=0, nxt=1)
//   fibo_series  out  4  current term, driven directly from the cur register
//
// Configuration macro: FIBO_GEN_MOD_WRAP_EN
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// fibo_adder4 -- combinational 4-bit adder producing (a + b) mod 16.
//   a    in  4  first operand (cur)
//   b    in  4  second operand (nxt)
//   sum  out 4  low four bits of a+b; carry is dropped on purpose
// -----------------------------------------------------------------------------
module fibo_adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] sum
);

  logic [4:0] full_s;

  // Widen before adding so the carry is visible, then keep the low nibble.
  always_comb begin
    full_s = {1'b0, a} + {1'b0, b};
    sum    = full_s[3:0];
  end

endmodule

`ifndef FIBO_GEN_MOD_WRAP_EN
// -----------------------------------------------------------------------------
// fibo_restart_detect -- flags the last term of the restarting series.
//   cur      in  4  term currently on the output
//   restart  out 1  high while cur == 13; the next edge reloads 0/1
// -----------------------------------------------------------------------------
module fibo_restart_detect (
  input  logic [3:0] cur,
  output logic       restart
);

  localparam logic [3:0] LAST_TERM = 4'd13;

  // Restart as soon as 13 is on the output, so the truncated sum 21->5
  // that nxt would otherwise hand over never reaches fibo_series.
  always_comb begin
    if (cur == LAST_TERM) begin
      restart = 1'b1;
    end else begin
      restart = 1'b0;
    end
  end

endmodule
`endif

// -----------------------------------------------------------------------------
// fibo_state_reg -- cur/nxt term registers.
//   clk      in  1  clock
//   reset    in  1  asynchronous active-low reset to cur=0, nxt=1
//   restart  in  1  reload 0/1 on the next edge instead of advancing
//   sum      in  4  (cur + nxt) mod 16 from the adder
//   cur      out 4  current term (registered)
//   nxt      out 4  following term (registered)
// -----------------------------------------------------------------------------
module fibo_state_reg (
  input  logic       clk,
  input  logic       reset,
  input  logic       restart,
  input  logic [3:0] sum,
  output logic [3:0] cur,
  output logic [3:0] nxt
);

  localparam logic [3:0] SEED_CUR = 4'd0;
  localparam logic [3:0] SEED_NXT = 4'd1;

  logic [3:0] cur_r;
  logic [3:0] nxt_r;
  logic [3:0] cur_next_s;
  logic [3:0] nxt_next_s;

  // Choose between advancing the series and reloading the seed pair.
  always_comb begin
    cur_next_s = nxt_r;
    nxt_next_s = sum;
    if (restart) begin
      cur_next_s = SEED_CUR;
      nxt_next_s = SEED_NXT;
    end else begin
      cur_next_s = nxt_r;
      nxt_next_s = sum;
    end
  end

  // Term registers; reset forces the seed pair immediately, independent of clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_r <= SEED_CUR;
      nxt_r <= SEED_NXT;
    end else begin
      cur_r <= cur_next_s;
      nxt_r <= nxt_next_s;
    end
  end

  assign cur = cur_r;
  assign nxt = nxt_r;

endmodule

// -----------------------------------------------------------------------------
// fibo_gen_top -- top level; see file header for the port summary.
// -----------------------------------------------------------------------------
module fibo_gen_top (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] fibo_series
);

  logic [3:0] cur_s;
  logic [3:0] nxt_s;
  logic [3:0] sum_s;
  logic       restart_s;

  fibo_adder4 u_adder (
    .a   (cur_s),
    .b   (nxt_s),
    .sum (sum_s)
  );

`ifdef FIBO_GEN_MOD_WRAP_EN
  // Pure mod-16 series: the adder result is always taken.
  assign restart_s = 1'b0;
`else
  fibo_restart_detect u_restart (
    .cur     (cur_s),
    .restart (restart_s)
  );
`endif

  fibo_state_reg u_state (
    .clk     (clk),
    .reset   (reset),
    .restart (restart_s),
    .sum     (sum_s),
    .cur     (cur_s),
    .nxt     (nxt_s)
  );

  // The output is the cur register itself, with no logic in between.
  assign fibo_series = cur_s;

endmodule

// File: tb/tb_fibo_gen_top.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_fibo_gen_top -- self-checking bench for fibo_gen_top.
//   The reference counts edges since the last reset and maps that count to a
//   true Fibonacci number (restarting every 8 terms, or mod 16 with period 24
//   when FIBO_GEN_MOD_WRAP_EN is defined). Directed scenarios use literal
//   tables; a random phase injects asynchronous reset pulses and holds.
// -----------------------------------------------------------------------------
module tb_fibo_gen_top;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] fibo_series;

  int  checks   = 0;
  int  failures = 0;
  bit  cmp_en   = 1'b0;
  int  k;

  fibo_gen_top dut (
    .clk         (clk),
    .reset       (reset),
    .fibo_series (fibo_series)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Plain integer Fibonacci: F(0)=0, F(1)=1.
  function automatic int fib(input int n);
    int a;
    int b;
    int t;
    a = 0;
    b = 1;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Expected term after k edges since reset release.
  function automatic int model_val(input int steps);
`ifdef FIBO_GEN_MOD_WRAP_EN
    return fib(steps % 24) % 16;
`else
    return fib(steps % 8);
`endif
  endfunction

  // Edge counter since reset; held at zero while reset is low.
  always @(posedge clk or negedge reset) begin
    if (!reset) k <= 0;
    else        k <= k + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every falling edge, the DUT output must match the reference.
  always @(negedge clk) begin
    if (cmp_en) chk("model_cmp", int'(fibo_series), model_val(k));
  end

`ifdef FIBO_GEN_MOD_WRAP_EN
  int exp_seq [25] = '{1,1,2,3,5,8,13,5,2,7,9,0,9,9,2,11,13,8,5,13,2,15,1,0,1};
`else
  int exp_seq [10] = '{1,1,2,3,5,8,13,0,1,1};
`endif
  int exp_after [3] = '{1,1,2};
  int vals [32];
  int found;
  int r;

  initial begin
    // Asynchronous reset assertion between edges.
    #1 reset = 1'b0;
    #1 cmp_en = 1'b1;
    chk("reset_async", int'(fibo_series), 0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("reset_hold", int'(fibo_series), 0);
    end
    @(negedge clk); #1 reset = 1'b1;

    // Series after release, pinned by a literal table.
    for (int i = 0; i < $size(exp_seq); i++) begin
      @(posedge clk); #1;
      chk("seq_dut", int'(fibo_series), exp_seq[i]);
      chk("seq_model", model_val(k), exp_seq[i]);
    end

    // Reset in the middle of the series, when the term 8 is showing.
    found = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (fibo_series == 4'd8) begin
        found = 1;
        break;
      end
    end
    chk("find_8", found, 1);
    #2 reset = 1'b0;
    #1 chk("reset_mid", int'(fibo_series), 0);
    @(posedge clk); #1;
    chk("reset_mid_hold", int'(fibo_series), 0);
    #3 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("after_mid", int'(fibo_series), exp_after[i]);
    end

    // Short pulse that never spans a rising edge.
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk("pulse_async", int'(fibo_series), 0);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("pulse_restart", int'(fibo_series), 1);

`ifndef FIBO_GEN_MOD_WRAP_EN
    // 32 free-running edges: value set, period 8, no 5 after 13.
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      vals[i] = int'(fibo_series);
    end
    for (int i = 0; i < 32; i++) begin
      chk("value_set", int'(vals[i] inside {0,1,2,3,5,8,13}), 1);
      if (i >= 8) chk("period8", vals[i], vals[i-8]);
      if (i >= 1 && vals[i-1] == 13) chk("after13", vals[i], 0);
    end
`endif

    // Random asynchronous reset pulses and multi-cycle holds.
    repeat (400) begin
      @(negedge clk);
      r = $urandom_range(0, 15);
      if (r == 0) begin
        #($urandom_range(1, 2)) reset = 1'b0;
        #1 chk("rand_pulse", int'(fibo_series), 0);
        #1 reset = 1'b1;
      end else if (r == 1) begin
        #1 reset = 1'b0;
        #1 chk("rand_hold", int'(fibo_series), 0);
        repeat ($urandom_range(1, 3)) @(negedge clk);
        #1 reset = 1'b1;
      end
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
